// File: rtl/uart_tx_engine_pkg.sv
// Shared types and helpers for the UART transmit engine: parity modes, FSM
// states, frame length and parity-bit calculation.
package uart_pkg;

   localparam int MAX_DATA_WIDTH = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10,
      PAR_MARK = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP1 = 3'd4,
      ST_STOP2 = 3'd5
   } tx_state_e;

   // Clocks occupied by one frame: start + data + optional parity + stop bit(s).
   function automatic int unsigned frame_clocks(
      input int unsigned baud_div,
      input int unsigned data_width,
      input parity_e     par,
      input logic        stop2
   );
      int unsigned bits;
      bits = 32'd2 + data_width + ((par != PAR_NONE) ? 32'd1 : 32'd0)
           + (stop2 ? 32'd1 : 32'd0);
      return (baud_div + 32'd1) * bits;
   endfunction

   function automatic logic parity_bit(
      input logic [MAX_DATA_WIDTH-1:0] data,
      input parity_e                   par
   );
      logic p;
      case (par)
         PAR_ODD:  p = ~(^data);
         PAR_EVEN: p = ^data;
         PAR_MARK: p = 1'b1;
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered occupancy counter, drop-on-full writes
// and a one-cycle overflow pulse; a pop frees room for a same-cycle write.
module uart_sync_fifo #(
   parameter int width      = 8,
   parameter int depth_log2 = 4
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Wr,
   input  logic [width-1:0]      WD,
   input  logic                  Rd,
   output logic [width-1:0]      RD,
   output logic                  Full,
   output logic                  Empty,
   output logic [depth_log2:0]   Cnt,
   output logic                  Ovf
);
   localparam int CW      = depth_log2 + 1;
   localparam int DEPTH_N = 1 << depth_log2;
   localparam logic [CW-1:0]         DEPTH   = CW'(DEPTH_N);
   localparam logic [CW-1:0]         CNT_ONE = CW'(1);
   localparam logic [depth_log2-1:0] PTR_ONE = depth_log2'(1);

   logic [width-1:0]      mem_r [0:DEPTH_N-1];
   logic [depth_log2-1:0] wr_ptr_r;
   logic [depth_log2-1:0] rd_ptr_r;
   logic [CW-1:0]         cnt_r;
   logic                  ovf_r;
   logic                  rd_en_s;
   logic                  wr_en_s;

   assign Full  = (cnt_r == DEPTH);
   assign Empty = (cnt_r == '0);
   assign Cnt   = cnt_r;
   assign Ovf   = ovf_r;
   assign RD    = mem_r[rd_ptr_r];

   // Accept a write when there is room now or the same-cycle pop makes room.
   always_comb begin
      rd_en_s = Rd && !Empty;
      wr_en_s = Wr && (!Full || rd_en_s);
   end

   // Pointers, occupancy counter and overflow pulse.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         ovf_r    <= 1'b0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (wr_en_s && !rd_en_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else if (rd_en_s && !wr_en_s) begin
            cnt_r <= cnt_r - CNT_ONE;
         end
         ovf_r <= Wr && !wr_en_s;
      end
   end

   // Storage array; a write in a reset cycle is discarded.
   always_ff @(posedge Clk) begin
      if (wr_en_s && !Rst) begin
         mem_r[wr_ptr_r] <= WD;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-fed frame serialiser with parity, one/two stop
// bits, CTS gating of frame starts and an RS-485 driver enable.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int pDataWidth  = 8,
   parameter int pDepth_Log2 = 4,
   parameter int pBaudWidth  = 16
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Wr,
   input  logic [pDataWidth-1:0]  WD,
   output logic                   Full,
   output logic                   Empty,
   output logic [pDepth_Log2:0]   Cnt,
   input  logic [pDepth_Log2:0]   Thr,
   output logic                   iTHE,
   output logic                   Ovf,
   input  logic [pBaudWidth-1:0]  Baud_Div,
   input  logic [1:0]             Parity,
   input  logic                   Stop2,
   input  logic                   CTS_En,
   input  logic                   xCTS,
   output logic                   TxD,
   output logic                   xDE,
   output logic                   TxIdle
);
   localparam int BIT_W = $clog2(pDataWidth);
   localparam logic [pBaudWidth-1:0] BAUD_ONE = pBaudWidth'(1);
   localparam logic [BIT_W-1:0]      BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(pDataWidth - 1);

   tx_state_e             state_r;
   logic [pBaudWidth-1:0] baud_r;
   logic [pBaudWidth-1:0] tick_cnt_r;
   logic [pDataWidth-1:0] shift_r;
   logic [BIT_W-1:0]      bits_left_r;
   logic                  par_bit_r;
   logic                  has_par_r;
   logic                  stop2_r;
   logic                  txd_r;
   logic                  xde_r;

   logic [pDataWidth-1:0] head_s;
   logic                  fifo_empty_s;
   logic [pDepth_Log2:0]  fifo_cnt_s;
   logic                  can_start_s;
   logic                  bit_done_s;
   logic                  frame_end_s;
   logic                  pop_s;

   uart_sync_fifo #(
      .width      (pDataWidth),
      .depth_log2 (pDepth_Log2)
   ) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .Wr    (Wr),
      .WD    (WD),
      .Rd    (pop_s),
      .RD    (head_s),
      .Full  (Full),
      .Empty (fifo_empty_s),
      .Cnt   (fifo_cnt_s),
      .Ovf   (Ovf)
   );

   assign Empty  = fifo_empty_s;
   assign Cnt    = fifo_cnt_s;
   assign iTHE   = (fifo_cnt_s <= Thr);
   assign TxIdle = (state_r == ST_IDLE) && fifo_empty_s;
   assign TxD    = txd_r;
   assign xDE    = xde_r;

   // A new frame starts from IDLE or straight out of the last stop bit.
   always_comb begin
      can_start_s = !fifo_empty_s && (!CTS_En || !xCTS);
      bit_done_s  = (tick_cnt_r == '0);
      frame_end_s = bit_done_s &&
                    (((state_r == ST_STOP1) && !stop2_r) || (state_r == ST_STOP2));
      pop_s       = can_start_s && ((state_r == ST_IDLE) || frame_end_s);
   end

   // Frame FSM, bit-period counter and shift register; the frame runs on
   // configuration latched at the pop.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r     <= ST_IDLE;
         baud_r      <= '0;
         tick_cnt_r  <= '0;
         shift_r     <= '0;
         bits_left_r <= '0;
         par_bit_r   <= 1'b0;
         has_par_r   <= 1'b0;
         stop2_r     <= 1'b0;
         txd_r       <= 1'b1;
         xde_r       <= 1'b0;
      end else if (pop_s) begin
         state_r    <= ST_START;
         txd_r      <= 1'b0;
         xde_r      <= 1'b1;
         shift_r    <= head_s;
         baud_r     <= Baud_Div;
         tick_cnt_r <= Baud_Div;
         par_bit_r  <= parity_bit(MAX_DATA_WIDTH'(head_s), parity_e'(Parity));
         has_par_r  <= (Parity != 2'b00);
         stop2_r    <= Stop2;
      end else if (state_r == ST_IDLE) begin
         txd_r <= 1'b1;
         xde_r <= 1'b0;
      end else if (!bit_done_s) begin
         tick_cnt_r <= tick_cnt_r - BAUD_ONE;
      end else begin
         tick_cnt_r <= baud_r;
         case (state_r)
            ST_START: begin
               state_r     <= ST_DATA;
               txd_r       <= shift_r[0];
               shift_r     <= {1'b0, shift_r[pDataWidth-1:1]};
               bits_left_r <= BIT_LAST;
            end
            ST_DATA: begin
               if (bits_left_r != '0) begin
                  txd_r       <= shift_r[0];
                  shift_r     <= {1'b0, shift_r[pDataWidth-1:1]};
                  bits_left_r <= bits_left_r - BIT_ONE;
               end else if (has_par_r) begin
                  state_r <= ST_PAR;
                  txd_r   <= par_bit_r;
               end else begin
                  state_r <= ST_STOP1;
                  txd_r   <= 1'b1;
               end
            end
            ST_PAR: begin
               state_r <= ST_STOP1;
               txd_r   <= 1'b1;
            end
            ST_STOP1: begin
               txd_r <= 1'b1;
               if (stop2_r) begin
                  state_r <= ST_STOP2;
               end else begin
                  state_r <= ST_IDLE;
                  xde_r   <= 1'b0;
               end
            end
            ST_STOP2: begin
               state_r <= ST_IDLE;
               txd_r   <= 1'b1;
               xde_r   <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               txd_r   <= 1'b1;
               xde_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: writes push expected frames, a line
// monitor decodes TxD and compares each frame's waveform against a model.
module tb_uart_tx_engine;
   localparam int DW = 8;
   localparam int DL = 4;
   localparam int BW = 16;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          Wr = 1'b0;
   logic [DW-1:0] WD = '0;
   logic          Full, Empty, iTHE, Ovf, TxD, xDE, TxIdle;
   logic [DL:0]   Cnt;
   logic [DL:0]   Thr = 5'd4;
   logic [BW-1:0] Baud_Div = 16'd3;
   logic [1:0]    Parity = 2'b00;
   logic          Stop2 = 1'b0;
   logic          CTS_En = 1'b0;
   logic          xCTS = 1'b0;

   uart_tx_engine #(.pDataWidth(DW), .pDepth_Log2(DL), .pBaudWidth(BW)) dut (
      .Clk(Clk), .Rst(Rst), .Wr(Wr), .WD(WD), .Full(Full), .Empty(Empty),
      .Cnt(Cnt), .Thr(Thr), .iTHE(iTHE), .Ovf(Ovf), .Baud_Div(Baud_Div),
      .Parity(Parity), .Stop2(Stop2), .CTS_En(CTS_En), .xCTS(xCTS),
      .TxD(TxD), .xDE(xDE), .TxIdle(TxIdle)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [DW-1:0] word;
      logic [1:0]    par;
      logic          stop2;
      logic [BW-1:0] baud;
      logic          b2b;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_busy = 1'b0;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Line levels of one frame, one entry per bit period.
   function automatic void frame_levels(input exp_t e, output logic [0:15] lv, output int n);
      int ones;
      ones = 0;
      n = 0;
      lv = '1;
      lv[n] = 1'b0; n++;
      for (int i = 0; i < DW; i++) begin
         lv[n] = e.word[i];
         ones += int'(e.word[i]);
         n++;
      end
      if (e.par != 2'b00) begin
         if (e.par == 2'b11)      lv[n] = 1'b1;
         else if (e.par == 2'b01) lv[n] = ((ones % 2) == 0);
         else                     lv[n] = ((ones % 2) == 1);
         n++;
      end
      lv[n] = 1'b1; n++;
      if (e.stop2) begin
         lv[n] = 1'b1; n++;
      end
   endfunction

   initial begin : monitor
      exp_t        cur;
      logic [0:15] lv;
      int          nbits, len, gap, bper, bad;
      logic        got[$];
      logic        de_ok;
      bit          stray;
      gap = 0; len = 0; bper = 1; nbits = 0; stray = 1'b0; de_ok = 1'b1;
      cur = '0; lv = '1;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            mon_busy = 1'b0;
            stray = 1'b0;
            got.delete();
            gap = 0;
         end else if (stray) begin
            if (TxIdle) stray = 1'b0;
         end else if (!mon_busy) begin
            if (TxD === 1'b0) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  stray = 1'b1;
                  $display("FAIL unexpected_frame: start bit at %0t, required idle line", $time);
               end else begin
                  cur = exp_q.pop_front();
                  frame_levels(cur, lv, nbits);
                  bper = int'(cur.baud) + 1;
                  len = nbits * bper;
                  if (cur.b2b) check("b2b_gap", gap, 32'd0);
                  got.delete();
                  got.push_back(TxD);
                  de_ok = xDE;
                  mon_busy = 1'b1;
               end
            end else begin
               gap++;
            end
         end else begin
            got.push_back(TxD);
            de_ok = de_ok & xDE;
         end
         if (mon_busy && got.size() == len) begin
            bad = -1;
            for (int i = 0; i < len; i++) begin
               if (bad < 0 && got[i] !== lv[i / bper]) bad = i;
            end
            vectors++;
            if (bad >= 0) begin
               miscompares++;
               $display("FAIL frame_wave word=%0h: sample %0d of %0d got %b, required %b",
                        cur.word, bad, len, got[bad], lv[bad / bper]);
            end
            check("frame_xde", {31'd0, de_ok}, 32'd1);
            mon_busy = 1'b0;
            gap = 0;
         end
      end
   end

   task automatic push_write(input logic [DW-1:0] d, input bit expect_out, input bit b2b);
      exp_t e;
      e.word = d; e.par = Parity; e.stop2 = Stop2; e.baud = Baud_Div; e.b2b = b2b;
      if (expect_out) exp_q.push_back(e);
      Wr = 1'b1;
      WD = d;
      tick();
      Wr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(TxIdle === 1'b1 && !mon_busy && exp_q.size() == 0) && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (!(TxIdle === 1'b1 && !mon_busy && exp_q.size() == 0)) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
      end
      tick();
   endtask

   task automatic wait_cnt(input logic [DL:0] target, input int budget);
      int n;
      n = 0;
      while (Cnt !== target && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (Cnt !== target) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_cnt: Cnt %0d, required %0d within %0d cycles", Cnt, target, budget);
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      logic [1:0] pcfg [5];
      logic       scfg [5];
      int         nw;
      pcfg = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
      scfg = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      repeat (3) tick();
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_txd", {31'd0, TxD}, 32'd1);
      check("rst_xde", {31'd0, xDE}, 32'd0);
      check("rst_txidle", {31'd0, TxIdle}, 32'd1);
      check("rst_full", {31'd0, Full}, 32'd0);
      check("rst_empty", {31'd0, Empty}, 32'd1);
      check("rst_cnt", {27'd0, Cnt}, 32'd0);
      check("rst_ithe", {31'd0, iTHE}, 32'd1);
      check("rst_ovf", {31'd0, Ovf}, 32'd0);
      tick();

      // Basic frame with write-to-start latency
      push_write(8'hA5, 1'b1, 1'b0);
      @(negedge Clk);
      check("lat_cnt", {27'd0, Cnt}, 32'd1);
      check("lat_txd_high", {31'd0, TxD}, 32'd1);
      tick();
      @(negedge Clk);
      check("lat_txd_start", {31'd0, TxD}, 32'd0);
      check("lat_xde", {31'd0, xDE}, 32'd1);
      check("lat_txidle", {31'd0, TxIdle}, 32'd0);
      wait_idle(200);
      check("basic_txidle", {31'd0, TxIdle}, 32'd1);
      check("basic_xde_off", {31'd0, xDE}, 32'd0);

      // Parity modes and two stop bits
      for (int i = 0; i < 5; i++) begin
         Parity = pcfg[i];
         Stop2 = scfg[i];
         push_write(8'h07, 1'b1, 1'b0);
         wait_idle(200);
      end

      // Randomised bursts; config only changes between bursts
      for (int r = 0; r < 10; r++) begin
         Baud_Div = BW'($urandom_range(0, 3));
         Parity = 2'($urandom_range(0, 3));
         Stop2 = 1'($urandom_range(0, 1));
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++) push_write(DW'($urandom_range(0, 255)), 1'b1, k > 0);
         wait_idle(600);
      end

      // Full, overflow, simultaneous push/pop at full, threshold, back-to-back drain
      Baud_Div = 16'd0; Parity = 2'b00; Stop2 = 1'b0;
      CTS_En = 1'b1; xCTS = 1'b1;
      for (int k = 0; k < 16; k++) push_write(DW'($urandom_range(0, 255)), 1'b1, k > 0);
      @(negedge Clk);
      check("full_cnt", {27'd0, Cnt}, 32'd16);
      check("full_flag", {31'd0, Full}, 32'd1);
      check("full_ithe", {31'd0, iTHE}, 32'd0);
      check("full_no_ovf", {31'd0, Ovf}, 32'd0);
      check("full_txd_held", {31'd0, TxD}, 32'd1);
      tick();
      push_write(8'h3C, 1'b0, 1'b0);
      @(negedge Clk);
      check("ovf_pulse", {31'd0, Ovf}, 32'd1);
      check("ovf_cnt", {27'd0, Cnt}, 32'd16);
      tick();
      @(negedge Clk);
      check("ovf_clear", {31'd0, Ovf}, 32'd0);
      check("ovf_txd_held", {31'd0, TxD}, 32'd1);
      tick();
      xCTS = 1'b0;
      push_write(8'hC3, 1'b1, 1'b1);
      @(negedge Clk);
      check("rw_full_cnt", {27'd0, Cnt}, 32'd16);
      check("rw_full_ovf", {31'd0, Ovf}, 32'd0);
      check("rw_full_start", {31'd0, TxD}, 32'd0);
      wait_cnt(5'd5, 400);
      check("thr_above", {31'd0, iTHE}, 32'd0);
      wait_cnt(5'd4, 100);
      check("thr_reach", {31'd0, iTHE}, 32'd1);
      wait_idle(400);
      CTS_En = 1'b0;

      // Baud change mid-frame affects only the next frame
      Baud_Div = 16'd3;
      push_write(8'h5A, 1'b1, 1'b0);
      repeat (10) tick();
      Baud_Div = 16'd7;
      push_write(8'h81, 1'b1, 1'b1);
      wait_idle(400);

      // Reset mid-frame, with a write in the reset cycle
      Baud_Div = 16'd3;
      push_write(8'hF0, 1'b1, 1'b0);
      repeat (17) tick();
      Rst = 1'b1;
      Wr = 1'b1;
      WD = 8'h99;
      tick();
      Rst = 1'b0;
      Wr = 1'b0;
      exp_q.delete();
      @(negedge Clk);
      check("mrst_txd", {31'd0, TxD}, 32'd1);
      check("mrst_xde", {31'd0, xDE}, 32'd0);
      check("mrst_cnt", {27'd0, Cnt}, 32'd0);
      check("mrst_empty", {31'd0, Empty}, 32'd1);
      repeat (60) tick();
      @(negedge Clk);
      check("mrst_txidle", {31'd0, TxIdle}, 32'd1);
      check("mrst_line", {31'd0, TxD}, 32'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmit engine with an integrated synchronous FIFO. It generalises the transmit path of the SSP UART: configurable data width, FIFO depth, baud divisor width, parity and stop-bit modes, RS-232 CTS flow control and RS-485 drive-enable. It sits between the SSP register interface (FIFO writes, configuration) and the serial line pins.

## Interface
Parameters:
- pDataWidth, 8, character width in bits; legal range 5..9.
- pDepth_Log2, 4, FIFO depth is 2**pDepth_Log2 entries.
- pBaudWidth, 16, width of the baud divisor.

Ports:
- Clk  in  1  system clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- Wr  in  1  FIFO write strobe, one word per asserted cycle.
- WD  in  pDataWidth  write data.
- Full  out  1  FIFO full.
- Empty  out  1  FIFO empty.
- Cnt  out  pDepth_Log2+1  FIFO occupancy, 0..2**pDepth_Log2.
- Thr  in  pDepth_Log2+1  low-water threshold.
- iTHE  out  1  Cnt <= Thr.
- Ovf  out  1  one-cycle pulse when a write is dropped.
- Baud_Div  in  pBaudWidth  bit period = Baud_Div+1 clocks.
- Parity  in  2  00 none, 01 odd, 10 even, 11 mark.
- Stop2  in  1  two stop bits when 1.
- CTS_En  in  1  enable CTS flow control.
- xCTS  in  1  active-low clear-to-send.
- TxD  out  1  serial data, idle high.
- xDE  out  1  RS-485 driver enable, active high.
- TxIdle  out  1  high when no frame is in progress and the FIFO is empty.

## Operation
- FIFO: write when Wr && (!Full || pop in the same cycle). A write while Full with no pop is dropped and raises Ovf for 1 cycle. A simultaneous write and pop leaves Cnt unchanged. Pointers wrap modulo depth. Cnt is a registered counter, not derived from pointer difference.
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2.
- IDLE -> START when !Empty && (!CTS_En || !xCTS). On that edge the engine pops the head word and latches word, Parity, Stop2 and Baud_Div. The frame always uses the latched values; mid-frame config changes have no effect on it.
- START: TxD=0 for one bit period.
- DATA: pDataWidth bits, LSB first.
- PAR: entered only when Parity != 00. Odd: bit makes the total count of 1s in data+parity odd. Even: makes it even. Mark: constant 1.
- STOP1: TxD=1. Then STOP2 if Stop2 is set, otherwise the next state is chosen:
  - Back-to-back: if the FIFO is non-empty and CTS permits, go directly to START with no idle gap.
  - Otherwise go to IDLE.
- Bit counter: down-counter loaded with the latched Baud_Div. The bit advances when the counter reaches 0. Baud_Div=0 gives 1 clock per bit.
- xCTS deassertion mid-frame does not abort the frame; it only blocks the next START.
- xDE = 1 in every state except IDLE.
- TxIdle = (state==IDLE) && Empty.

## Timing
- Reset values:
  - TxD=1, xDE=0, TxIdle=1, Full=0, Empty=1, Cnt=0, iTHE=1 (Thr>=0), Ovf=0.
  - FSM=IDLE, FIFO pointers=0.
- Write at edge N: Cnt/Empty update visible after edge N. With the engine idle and CTS ok, the pop and START transition happen at edge N+1, so TxD falls after edge N+1 (2-cycle write-to-start latency).
- Frame length in clocks = (Baud_Div+1) × (1 + pDataWidth + (Parity!=0) + 1 + Stop2).
- Reset asserted mid-frame: at the next edge TxD=1, xDE=0, the FIFO is flushed (Cnt=0), and any write in the same cycle is ignored.
- All outputs are registered except Full, Empty, iTHE and TxIdle, which are combinational from registers.

## Structure
- Package uart_pkg:
  - Parity enum (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK).
  - FSM state enum.
  - Frame-length helper function.
- Sub-module uart_sync_fifo:
  - Parameters: width, depth_log2.
  - Provides Wr/Rd/Full/Empty/Cnt/Ovf, including simultaneous read/write handling.
- The top-level instantiates the FIFO and holds the FSM, baud counter and shift register.

## Test plan
- Basic frame: Baud_Div=3, Parity=00, Stop2=0, write 0xA5. TxD = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks (40 clocks total). xDE high for all 40 clocks. TxIdle returns to 1 afterward.
- Parity: write 0x07 with Parity=01 -> parity bit 0. Same word with Parity=10 -> parity bit 1. Parity=11 -> parity bit 1. Stop2=1 -> two high stop bits.
- Full / overflow: hold xCTS=1 with CTS_En=1, then write 17 words into the depth-16 FIFO. Cnt=16, Full=1, Ovf pulses on the 17th write, TxD stays 1. Release xCTS -> the first 16 words go out back-to-back with no gap; the 17th word never appears.
- Threshold: Thr=4. iTHE=0 at Cnt=5 and rises to 1 on the pop that makes Cnt=4. A simultaneous write and pop at Cnt=16 keeps Cnt=16 with no Ovf.
- Reset mid-frame: assert Rst during DATA bit 3. Next edge: TxD=1, xDE=0, Cnt=0; no further start bit appears.
- Config change mid-frame: change Baud_Div 3->7 during DATA. The current frame keeps 4-clock bits; the next frame uses 8-clock bits.
